// File: rtl/trng_buffer.sv
// trng_buffer: prefetches random words from the TRNG generator into a small FIFO.
// It drops the stale first word after reset/alarm clear and screens captures with
// a repetition-count health test. Words are served over a valid/ready read port.
module trng_buffer #(
  parameter int W       = 32,
  parameter int DEPTH   = 4,
  parameter int RCT_LIM = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     trng_gen,
  input  logic                     trng_rdy,
  input  logic [W-1:0]             trng_rdn,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     alarm,
  input  logic                     alarm_clr
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int OCC_W = AW + 2;
  localparam int RW    = $clog2(RCT_LIM);
  localparam logic [RW-1:0] REP_MAX = RW'(RCT_LIM - 1);

  logic [W-1:0]     mem [DEPTH];
  // Head/tail carry one wrap bit above the index so tail-head yields 0..DEPTH.
  logic [AW:0]      head;
  logic [AW:0]      tail;
  logic             prime;
  logic             inflight;
  logic [W-1:0]     last_word;
  logic [RW-1:0]    rep_cnt;

  logic             full;
  logic             pop;
  logic             push;
  logic             capture;
  logic             repeat_word;
  logic [RW-1:0]    rep_next;
  logic             alarm_d;
  logic [LVL_W-1:0] level_eff;
  logic [OCC_W-1:0] occ;
  logic             gen_next;

  // Occupancy, read port, capture decisions and next request level.
  always_comb begin
    level       = tail - head;
    full        = (level == LVL_W'(DEPTH));
    rd_valid    = (level != '0) && !alarm;
    rd_data     = mem[head[AW-1:0]];
    pop         = rd_valid && rd_ready;
    capture     = trng_rdy && !prime && !alarm && !alarm_clr;
    repeat_word = (trng_rdn == last_word);
    rep_next    = (rep_cnt == REP_MAX) ? REP_MAX : rep_cnt + RW'(1);
    push        = capture && !repeat_word && !full;
    alarm_d     = alarm_clr ? 1'b0
                : (alarm || (capture && repeat_word && (rep_next == REP_MAX)));
    // A clear flushes the FIFO, so the request decision sees an empty buffer.
    level_eff   = alarm_clr ? '0 : level;
    occ         = {1'b0, level_eff} + OCC_W'(inflight);
    // Next alarm state gates gen so the request drops on the alarm edge itself.
    gen_next    = !alarm_d && (occ < OCC_W'(DEPTH));
  end

  // FIFO storage, pointers, health-test state and generator handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      head      <= '0;
      tail      <= '0;
      prime     <= 1'b1;
      inflight  <= 1'b0;
      last_word <= '0;
      rep_cnt   <= '0;
      alarm     <= 1'b0;
      trng_gen  <= 1'b0;
    end else begin
      trng_gen <= gen_next;
      alarm    <= alarm_d;

      if (trng_rdy)      inflight <= 1'b0;
      else if (trng_gen) inflight <= 1'b1;

      if (alarm_clr) begin
        rep_cnt <= '0;
        head    <= tail;
        // A word arriving with the clear is consumed as the stale prime word.
        prime   <= !trng_rdy;
      end else begin
        if (trng_rdy && prime) prime <= 1'b0;
        if (capture) begin
          last_word <= trng_rdn;
          rep_cnt   <= repeat_word ? rep_next : '0;
        end
        if (push) begin
          mem[tail[AW-1:0]] <= trng_rdn;
          tail              <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
      end
    end
  end

  // A captured word with the FIFO full means the generator broke its contract.
  assert property (@(posedge clk) disable iff (!rst)
    !(capture && !repeat_word && full));

endmodule
